// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC step, NOP encoding, reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: ROM port, hazard/control requests and IF/ID outputs.
interface fetch_ctrl_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_cnt;

  // Fetch controller side.
  modport master (
    output rom_addr,
    input  rom_inst,
    input  stall,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    input  resume,
    output ifid_inst,
    output ifid_pc,
    output ifid_valid,
    output halted,
    output fetch_cnt
  );

  // ROM / hazard unit / decode side.
  modport slave (
    input  rom_addr,
    output rom_inst,
    output stall,
    output flush,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    output resume,
    input  ifid_inst,
    input  ifid_pc,
    input  ifid_valid,
    input  halted,
    input  fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl_ifid_reg.sv
// Generic pipeline stage register: clear kills the valid bit, hold freezes
// everything, otherwise the incoming word/pc is captured as valid.
module ifid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d_inst,
  input  logic [W-1:0] d_pc,
  output logic [W-1:0] q_inst,
  output logic [W-1:0] q_pc,
  output logic         q_valid
);

  logic [W-1:0] inst_d, inst_q;
  logic [W-1:0] pc_d, pc_q;
  logic         valid_d, valid_q;

  // Next-state: clear beats hold; inst/pc are left untouched on clear.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (!hold) begin
      inst_d  = d_inst;
      pc_d    = d_pc;
      valid_d = 1'b1;
    end
  end

  // Stage register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign q_inst  = inst_q;
  assign q_pc    = pc_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the ROM address and
// sequences the IF/ID register through BOOT / RUN / HALT.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);
  import cpu_pkg::*;

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  cnt_d, cnt_q;
  logic         halted_d, halted_q;
  logic         ifid_hold;
  logic         ifid_clear;
  logic [31:0]  redirect_tgt;

  assign redirect_tgt = align_pc(bus.redirect_pc);

  // Next-state for FSM, PC and delivery counter, plus IF/ID hold/clear.
  // A counted delivery is exactly the RUN case where IF/ID captures.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ifid_clear = 1'b1;
        if (bus.redirect_valid) pc_d = redirect_tgt;
        state_d = ST_RUN;
      end
      ST_HALT: begin
        ifid_clear = 1'b1;
        if (bus.redirect_valid) pc_d = redirect_tgt;
        if (bus.resume) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect_valid) begin
          pc_d       = redirect_tgt;
          ifid_clear = 1'b1;
        end else if (bus.flush) begin
          pc_d       = pc_q + PC_STEP;
          ifid_clear = 1'b1;
          if (bus.halt_req) state_d = ST_HALT;
        end else if (bus.stall) begin
          ifid_hold = 1'b1;
        end else begin
          pc_d  = pc_q + PC_STEP;
          cnt_d = cnt_q + 32'd1;
          if (bus.halt_req) state_d = ST_HALT;
        end
      end
      default: begin
        ifid_clear = 1'b1;
        state_d    = ST_BOOT;
      end
    endcase
    halted_d = (state_d == ST_HALT);
  end

  // FSM, PC, counter and registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  ifid_reg #(.W(32)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .hold    (ifid_hold),
    .clear   (ifid_clear),
    .d_inst  (bus.rom_inst),
    .d_pc    (pc_q),
    .q_inst  (bus.ifid_inst),
    .q_pc    (bus.ifid_pc),
    .q_valid (bus.ifid_valid)
  );

  assign bus.rom_addr  = pc_q;
  assign bus.halted    = halted_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run compared against a behavioural fetch model.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  logic [31:0] rom [64];
  assign bus.rom_inst = rom[bus.rom_addr[7:2]];

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
  bit          m_valid, m_halted, m_boot;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
    m_valid = 0; m_halted = 0; m_boot = 1;
  endtask

  // One clock of the fetch rules, evaluated from the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_boot = 0; m_valid = 0;
      if (bus.redirect_valid) m_pc = tgt;
    end else if (m_halted) begin
      m_valid = 0;
      if (bus.redirect_valid) m_pc = tgt;
      if (bus.resume) m_halted = 0;
    end else if (bus.redirect_valid) begin
      m_pc = tgt; m_valid = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_pc = m_pc + 32'd4;
      if (bus.halt_req) m_halted = 1;
    end else if (!bus.stall) begin
      m_inst = rom[m_pc[7:2]]; m_ipc = m_pc; m_valid = 1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      if (bus.halt_req) m_halted = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0;
    bus.redirect_pc = 32'h0; bus.halt_req = 0; bus.resume = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.ifid_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_ifid: got valid=%b inst=%h pc=%h, want 0/0/0", bus.ifid_valid, bus.ifid_inst, bus.ifid_pc);
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.fetch_cnt !== 32'h0 || bus.rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got halted=%b cnt=%h addr=%h, want 0/0/0", bus.halted, bus.fetch_cnt, bus.rom_addr);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_inst [5];
    exp_inst[0] = 32'h00100443; exp_inst[1] = 32'h00201025;
    exp_inst[2] = 32'h041018E1; exp_inst[3] = 32'h04202021; exp_inst[4] = 32'h0;
    do_reset();
    tick();
    checks++;
    if (bus.ifid_valid !== 1'b0) begin
      errors++; $display("FAIL boot_valid: got %b, want 0", bus.ifid_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.ifid_valid !== 1'b1 || bus.ifid_inst !== exp_inst[i] || bus.ifid_pc !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_%0d: got valid=%b inst=%h pc=%h, want 1 %h %h", i, bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, exp_inst[i], 32'(4 * i));
      end
    end
    checks++;
    if (bus.fetch_cnt !== 32'd5) begin
      errors++; $display("FAIL seq_cnt: got %0d, want 5", bus.fetch_cnt);
    end
  endtask

  // Stall 3 cycles while 00201025 is in IF/ID, then a stalled redirect to 7.
  task automatic test_stall_redirect();
    do_reset();
    tick(); tick(); tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.ifid_inst !== 32'h00201025 || bus.ifid_pc !== 32'h4 || bus.ifid_valid !== 1'b1 || bus.rom_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall_%0d: got inst=%h pc=%h valid=%b addr=%h, want 00201025 4 1 8", i, bus.ifid_inst, bus.ifid_pc, bus.ifid_valid, bus.rom_addr);
      end
    end
    bus.stall = 0;
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h041018E1 || bus.ifid_pc !== 32'h8) begin
      errors++; $display("FAIL stall_release: got inst=%h pc=%h, want 041018e1 8", bus.ifid_inst, bus.ifid_pc);
    end
    bus.stall = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'h7;
    tick();
    bus.stall = 0; bus.redirect_valid = 0;
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.rom_addr !== 32'h4) begin
      errors++; $display("FAIL redirect_bubble: got valid=%b addr=%h, want 0 4", bus.ifid_valid, bus.rom_addr);
    end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h00201025 || bus.ifid_pc !== 32'h4 || bus.ifid_valid !== 1'b1) begin
      errors++; $display("FAIL redirect_target: got inst=%h pc=%h valid=%b, want 00201025 4 1", bus.ifid_inst, bus.ifid_pc, bus.ifid_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    tick(); tick(); tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.rom_addr !== 32'hC || bus.fetch_cnt !== 32'd2) begin
      errors++; $display("FAIL flush: got valid=%b addr=%h cnt=%0d, want 0 c 2", bus.ifid_valid, bus.rom_addr, bus.fetch_cnt);
    end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h04202021 || bus.ifid_pc !== 32'hC || bus.fetch_cnt !== 32'd3) begin
      errors++; $display("FAIL flush_next: got inst=%h pc=%h cnt=%0d, want 04202021 c 3", bus.ifid_inst, bus.ifid_pc, bus.fetch_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick();
    bus.halt_req = 1;
    tick();
    bus.halt_req = 0;
    checks++;
    if (bus.ifid_inst !== 32'h00201025 || bus.ifid_valid !== 1'b1 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL halt_enter: got inst=%h valid=%b halted=%b, want 00201025 1 1", bus.ifid_inst, bus.ifid_valid, bus.halted);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin bus.redirect_valid = 1; bus.redirect_pc = 32'h0; bus.halt_req = 1; end
      tick();
      bus.redirect_valid = 0; bus.halt_req = 0;
      checks++;
      if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0) begin
        errors++; $display("FAIL halt_hold_%0d: got halted=%b valid=%b, want 1 0", i, bus.halted, bus.ifid_valid);
      end
    end
    checks++;
    if (bus.rom_addr !== 32'h0) begin
      errors++; $display("FAIL halt_redirect: got addr=%h, want 0", bus.rom_addr);
    end
    bus.resume = 1;
    tick();
    bus.resume = 0;
    checks++;
    if (bus.halted !== 1'b0 || bus.ifid_valid !== 1'b0) begin
      errors++; $display("FAIL resume: got halted=%b valid=%b, want 0 0", bus.halted, bus.ifid_valid);
    end
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h00100443 || bus.ifid_pc !== 32'h0 || bus.ifid_valid !== 1'b1) begin
      errors++; $display("FAIL resume_fetch: got inst=%h pc=%h valid=%b, want 00100443 0 1", bus.ifid_inst, bus.ifid_pc, bus.ifid_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 0;
    checks++;
    if (bus.rom_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_target: got %h, want fffffffc", bus.rom_addr);
    end
    tick();
    checks++;
    if (bus.ifid_pc !== 32'hFFFF_FFFC || bus.ifid_inst !== 32'h0 || bus.ifid_valid !== 1'b1 || bus.rom_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_step: got pc=%h inst=%h valid=%b addr=%h, want fffffffc 0 1 0", bus.ifid_pc, bus.ifid_inst, bus.ifid_valid, bus.rom_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); tick(); tick(); tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_inst !== 32'h0 || bus.ifid_pc !== 32'h0 ||
        bus.fetch_cnt !== 32'h0 || bus.halted !== 1'b0 || bus.rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b inst=%h pc=%h cnt=%h halted=%b addr=%h, want all 0",
               bus.ifid_valid, bus.ifid_inst, bus.ifid_pc, bus.fetch_cnt, bus.halted, bus.rom_addr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.ifid_inst !== 32'h00100443 || bus.ifid_valid !== 1'b1 || bus.fetch_cnt !== 32'd1) begin
      errors++; $display("FAIL async_restart: got inst=%h valid=%b cnt=%0d, want 00100443 1 1", bus.ifid_inst, bus.ifid_valid, bus.fetch_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.stall          = ($urandom_range(0, 99) < 20);
      bus.flush          = ($urandom_range(0, 99) < 10);
      bus.redirect_valid = ($urandom_range(0, 99) < 10);
      bus.redirect_pc    = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      bus.halt_req       = ($urandom_range(0, 99) < 6);
      bus.resume         = ($urandom_range(0, 99) < 30);
      tick();
      checks++;
      if (bus.ifid_valid !== m_valid || bus.halted !== m_halted || bus.rom_addr !== m_pc || bus.fetch_cnt !== m_cnt ||
          (m_valid && (bus.ifid_inst !== m_inst || bus.ifid_pc !== m_ipc))) begin
        errors++;
        $display("FAIL rand_%0d: got v=%b h=%b a=%h c=%h i=%h p=%h, want v=%b h=%b a=%h c=%h i=%h p=%h", n,
                 bus.ifid_valid, bus.halted, bus.rom_addr, bus.fetch_cnt, bus.ifid_inst, bus.ifid_pc,
                 m_valid, m_halted, m_pc, m_cnt, m_inst, m_ipc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h00100443; rom[1] = 32'h00201025;
    rom[2] = 32'h041018E1; rom[3] = 32'h04202021;
    idle_inputs();
    model_reset();
    test_reset();
    test_sequence();
    test_stall_redirect();
    test_flush();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
